// File: rtl/pkg_dtypes.sv
// Shared datatypes for the dispatch path: the instruction-queue entry and op classes.
package pkg_dtypes;

   localparam int unsigned NUM_OP_CLASSES = 4;

   typedef enum logic [1:0] {
      OpAlu    = 2'd0,
      OpMul    = 2'd1,
      OpMem    = 2'd2,
      OpBranch = 2'd3
   } type_op_class;

   typedef struct packed {
      logic [7:0] opcode;
      logic [5:0] rd;
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic [5:0] tag;
   } type_iqueue_entry;

endpackage

// File: rtl/eu_rr_picker.sv
// Combinational rotate-priority picker: first request at or after ptr_i (mod N) wins.
module eu_rr_picker #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          any_o
);

   // Rotate so that bit 0 of req_rot is the request at ptr_i.
   logic [N-1:0] req_rot;
   assign req_rot = N'({req_i, req_i} >> ptr_i);

   int unsigned idx;

   // Scan the rotated vector from its low end and map the hit back to an EU index.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx       = 0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!any_o && req_rot[j]) begin
            any_o = 1'b1;
            idx   = int'(ptr_i) + j;
            if (idx >= N) idx = idx - N;
            gnt_idx_o        = IW'(idx);
            gnt_o[gnt_idx_o] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eu_dispatch_sched.sv
// Dispatch scheduler: steers one decoded-instruction stream into NUM_EU exec-unit queues
// using per-EU credits and round-robin selection among class-capable EUs.
// Optional feature macro: EU_DISPATCH_PERF_EN adds dispatch/stall perf counters.
module eu_dispatch_sched
   import pkg_dtypes::*;
#(
   parameter int unsigned NUM_EU            = 4,
   parameter int unsigned LOG2_QUEUE_LENGTH = 4,
   parameter int unsigned NUM_CLASSES       = 4,
   parameter logic [NUM_EU*NUM_CLASSES-1:0] EU_CLASS_MASK = '1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  type_iqueue_entry                           instr_i,
   input  logic [$clog2(NUM_CLASSES)-1:0]             instr_class_i,
   input  logic                                       instr_valid_i,
   output logic                                       instr_ready_o,
   output type_iqueue_entry                           eu_instr_o,
   output logic [NUM_EU-1:0]                          eu_valid_o,
   input  logic [NUM_EU-1:0]                          eu_pop_i,
   input  logic [NUM_EU-1:0]                          eu_full_i,
   output logic [NUM_EU*(LOG2_QUEUE_LENGTH+1)-1:0]    credit_o
`ifdef EU_DISPATCH_PERF_EN
   ,
   output logic [NUM_EU*32-1:0]                       perf_disp_cnt_o,
   output logic [31:0]                                perf_stall_cnt_o
`endif
);

   localparam int unsigned CW = LOG2_QUEUE_LENGTH + 1;
   localparam int unsigned PW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
   localparam logic [CW-1:0] QDEPTH = {1'b1, {LOG2_QUEUE_LENGTH{1'b0}}};

   logic [NUM_EU-1:0][CW-1:0]          credit_q, credit_d;
   logic [NUM_EU-1:0][NUM_CLASSES-1:0] cls_row;
   logic [PW-1:0]                      rr_ptr_q, rr_ptr_d;
   logic [NUM_EU-1:0]                  elig, gnt, eu_valid_q;
   logic [PW-1:0]                      gnt_idx;
   logic                               any_elig, hs;
   type_iqueue_entry                   eu_instr_q;

   assign cls_row = EU_CLASS_MASK;

   // An EU is eligible when it can execute the class and still has a free slot.
   always_comb begin
      elig = '0;
      for (int unsigned e = 0; e < NUM_EU; e++) begin
         elig[e] = cls_row[e][instr_class_i] && (credit_q[e] != '0);
      end
   end

   eu_rr_picker #(
      .N (NUM_EU)
   ) u_picker (
      .req_i     (elig),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (any_elig)
   );

   assign instr_ready_o = any_elig & ~reset;
   assign hs            = instr_valid_i & instr_ready_o;
   assign rr_ptr_d      = (gnt_idx == PW'(NUM_EU - 1)) ? '0 : gnt_idx + 1'b1;

   // Credits are charged at the handshake so the output register can never overrun a queue.
   always_comb begin
      credit_d = credit_q;
      for (int unsigned e = 0; e < NUM_EU; e++) begin
         if (hs && gnt[e]) credit_d[e] = credit_d[e] - 1'b1;
         if (eu_pop_i[e])  credit_d[e] = credit_d[e] + 1'b1;
      end
   end

   // Credit array, round-robin pointer and the one-entry output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         credit_q   <= {NUM_EU{QDEPTH}};
         rr_ptr_q   <= '0;
         eu_valid_q <= '0;
         eu_instr_q <= '0;
      end else begin
         credit_q   <= credit_d;
         eu_valid_q <= hs ? gnt : '0;
         if (hs) begin
            rr_ptr_q   <= rr_ptr_d;
            eu_instr_q <= instr_i;
         end
      end
   end

   assign eu_valid_o = eu_valid_q;
   assign eu_instr_o = eu_instr_q;
   assign credit_o   = credit_q;

`ifdef EU_DISPATCH_PERF_EN
   logic [NUM_EU-1:0][31:0] perf_disp_q;
   logic [31:0]             perf_stall_q;

   // Free-running wrap-around counters of dispatches per EU and stalled valid cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_disp_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         for (int unsigned e = 0; e < NUM_EU; e++) begin
            if (hs && gnt[e]) perf_disp_q[e] <= perf_disp_q[e] + 1'b1;
         end
         if (instr_valid_i && !instr_ready_o) perf_stall_q <= perf_stall_q + 1'b1;
      end
   end

   assign perf_disp_cnt_o  = perf_disp_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
   for (genvar e = 0; e < NUM_EU; e++) begin : g_chk
      // A credit above the queue depth also catches a wrapped underflow.
      a_credit_range: assert property (@(posedge clk) disable iff (reset)
         credit_q[e] <= QDEPTH);
      a_no_underflow: assert property (@(posedge clk) disable iff (reset)
         !(hs && gnt[e] && credit_q[e] == '0));
      a_no_write_full: assert property (@(posedge clk) disable iff (reset)
         !(eu_valid_o[e] && eu_full_i[e]));
   end
   a_valid_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(eu_valid_o));
`endif

endmodule

// File: tb/tb_eu_dispatch_sched.sv
// Self-checking bench for eu_dispatch_sched (NUM_EU=4, LOG2_QUEUE_LENGTH=2, NUM_CLASSES=4).
// Class 2 runs only on EU3; every other class runs on all EUs.
// Build with EU_DISPATCH_PERF_EN defined to also exercise the perf counters.
module tb_eu_dispatch_sched;
   import pkg_dtypes::*;

   localparam int unsigned NE = 4;
   localparam int unsigned NC = 4;
   localparam logic [15:0] MASK_P = 16'hFBBB;

   typedef struct packed {
      logic [3:0]       vld;
      type_iqueue_entry ins;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   type_iqueue_entry instr;
   logic [1:0]       instr_class;
   logic             instr_valid;
   logic             instr_ready;
   type_iqueue_entry eu_instr;
   logic [3:0]       eu_valid;
   logic [3:0]       eu_pop;
   logic [3:0]       eu_full;
   logic [11:0]      credit;
`ifdef EU_DISPATCH_PERF_EN
   logic [127:0]     perf_disp;
   logic [31:0]      perf_stall;
`endif

   eu_dispatch_sched #(
      .NUM_EU            (NE),
      .LOG2_QUEUE_LENGTH (2),
      .NUM_CLASSES       (NC),
      .EU_CLASS_MASK     (MASK_P)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .instr_i          (instr),
      .instr_class_i    (instr_class),
      .instr_valid_i    (instr_valid),
      .instr_ready_o    (instr_ready),
      .eu_instr_o       (eu_instr),
      .eu_valid_o       (eu_valid),
      .eu_pop_i         (eu_pop),
      .eu_full_i        (eu_full),
      .credit_o         (credit)
`ifdef EU_DISPATCH_PERF_EN
      ,
      .perf_disp_cnt_o  (perf_disp),
      .perf_stall_cnt_o (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   logic [3:0][3:0]  mask_row;
   int               n_checks = 0;
   int               n_fail = 0;
   int               m_credit[NE];
   int               m_occ[NE];
   int               m_rr;
   logic [3:0]       cur_vld;
   type_iqueue_entry last_instr;
   exp_t             sb[$];

   assign mask_row = MASK_P;

   // An op class that no EU can execute would stall forever.
   always @(posedge clk) begin
      if (!reset && instr_valid) begin
         assert (|{mask_row[0][instr_class], mask_row[1][instr_class],
                   mask_row[2][instr_class], mask_row[3][instr_class]})
         else $error("op class %0d has no capable EU", instr_class);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_credits();
      logic [11:0] r;
      for (int k = 0; k < NE; k++) r[k*3 +: 3] = 3'(m_credit[k]);
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NE; k++) begin
         m_credit[k] = 4;
         m_occ[k]    = 0;
      end
      m_rr       = 0;
      cur_vld    = '0;
      last_instr = '0;
      sb.delete();
   endtask

   // Reset for one clock; v keeps instr_valid high to show it is ignored.
   task automatic do_reset(input logic v);
      reset       = 1'b1;
      instr_valid = v;
      instr_class = 2'd0;
      eu_pop      = '0;
      eu_full     = '0;
      #2;
      check("rst_ready", 64'(instr_ready), 64'(0));
      @(posedge clk);
      #1;
      check("rst_vld", 64'(eu_valid), 64'(0));
      check("rst_instr", 64'(eu_instr), 64'(0));
      check("rst_credit", 64'(credit), 64'(12'h924));
      reset = 1'b0;
      model_reset();
   endtask

   // One clock: drive inputs, predict, push expectation, clock, pop and compare.
   task automatic step(input logic v, input logic [1:0] cls, input logic [3:0] pop);
      logic [3:0] elig;
      logic       exp_rdy;
      logic       hs;
      int         sel;
      exp_t       x;
      instr_valid = v;
      instr_class = cls;
      eu_pop      = pop;
      instr       = type_iqueue_entry'($urandom);
      #2;
      for (int e = 0; e < NE; e++) elig[e] = mask_row[e][cls] && (m_credit[e] != 0);
      exp_rdy = |elig;
      check("ready", 64'(instr_ready), 64'(exp_rdy));
      hs  = v && exp_rdy;
      sel = -1;
      if (hs) begin
         for (int i = 0; i < NE; i++) begin
            int idx;
            idx = (m_rr + i) % NE;
            if (sel < 0 && elig[idx]) sel = idx;
         end
         x.vld = 4'(1 << sel);
         x.ins = instr;
         sb.push_back(x);
         m_credit[sel]--;
         m_rr = (sel + 1) % NE;
      end
      for (int k = 0; k < NE; k++) begin
         m_credit[k] += int'(pop[k]);
         m_occ[k]    += int'(cur_vld[k]) - int'(pop[k]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NE; k++) eu_full[k] = (m_occ[k] == 4);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check("disp_vld", 64'(eu_valid), 64'(x.vld));
         check("disp_instr", 64'(eu_instr), 64'(x.ins));
         cur_vld    = x.vld;
         last_instr = x.ins;
      end else begin
         check("idle_vld", 64'(eu_valid), 64'(0));
         check("hold_instr", 64'(eu_instr), 64'(last_instr));
         cur_vld = '0;
      end
      check("credits", 64'(credit), 64'(model_credits()));
   endtask

   initial begin
      reset       = 1'b1;
      instr       = '0;
      instr_class = '0;
      instr_valid = 1'b0;
      eu_pop      = '0;
      eu_full     = '0;
      model_reset();
      do_reset(1'b0);

      // Round-robin back-to-back dispatch, then drain all credits.
      for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'b0000);
      check("t1_credits", 64'(credit), 64'(12'h492));
      for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'b0000);
      check("t2_empty_credit", 64'(credit), 64'(0));
      step(1'b1, 2'd0, 4'b0000);
      check("t2_ready_low", 64'(instr_ready), 64'(0));
      step(1'b1, 2'd0, 4'b0100);
      step(1'b1, 2'd0, 4'b0000);
      check("t2_eu2_only", 64'(eu_valid), 64'(4'b0100));

      // Dispatch to EU1 and pop EU1 in the same cycle: credit unchanged.
      step(1'b0, 2'd0, 4'b0010);
      check("t3_pre", 64'(credit[5:3]), 64'(1));
      step(1'b1, 2'd0, 4'b0010);
      check("t3_eu1", 64'(eu_valid), 64'(4'b0010));
      check("t3_credit1", 64'(credit[5:3]), 64'(1));
      step(1'b0, 2'd0, 4'b0000);

      // Class 2 only on EU3: four fit, the fifth waits for a pop.
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 4'b0000);
      check("t4_eu3_credit", 64'(credit[11:9]), 64'(0));
      step(1'b1, 2'd2, 4'b0000);
      check("t4_stall", 64'(instr_ready), 64'(0));
      step(1'b1, 2'd2, 4'b1000);
      step(1'b1, 2'd2, 4'b0000);
      check("t4_eu3", 64'(eu_valid), 64'(4'b1000));

      // Build credits {0,1,3,4}, then reset mid-burst.
      do_reset(1'b0);
      for (int i = 0; i < 13; i++) step(1'b1, 2'd0, 4'b0000);
      step(1'b0, 2'd0, 4'b1100);
      step(1'b0, 2'd0, 4'b1100);
      step(1'b0, 2'd0, 4'b1000);
      check("t5_credits", 64'(credit), 64'(12'h8C8));
      step(1'b1, 2'd0, 4'b0000);
      do_reset(1'b1);
      step(1'b1, 2'd0, 4'b0000);
      check("t5_rr_zero", 64'(eu_valid), 64'(4'b0001));

`ifdef EU_DISPATCH_PERF_EN
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b0000);
      for (int k = 0; k < NE; k++) check("perf_disp", 64'(perf_disp[k*32 +: 32]), 64'(4));
      check("perf_stall", 64'(perf_stall), 64'(3));
`endif

      instr_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
